// File: rtl/freq_pkg.sv
// Shared constants for the board clock domain, used by the frequency meter
// and the frequency divider.
package freq_pkg;

    localparam int CLK_HZ_DEFAULT = 12000000;
    localparam int CNT_W_DEFAULT  = 32;
    localparam int GATE_1S        = CLK_HZ_DEFAULT;

endpackage

// File: rtl/frequency_meter_sync.sv
// Two-flop synchronizer plus an edge register. Emits a one-cycle pulse per
// rising edge of an asynchronous input. Also suitable for button inputs.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out   = sync_q;
    assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/frequency_meter.sv
// Counts rising edges of sig_in over a gate window of GATE_CYCLES clocks and
// publishes the saturating count with a one-cycle valid strobe per window.
module frequency_meter
    import freq_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             overflow,
    output logic             valid
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic sigLevel;
    logic risePulse;
    logic edgeSeen;

    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [CNT_W-1:0] edgeInc;
    logic             satInc;

    sync_edge_detect u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (sig_in),
        .sync_out   (sigLevel),
        .rise_pulse (risePulse)
    );

    assign edgeSeen = risePulse & sigLevel;

    // The terminal-cycle edge is folded into the closing window's count.
    always_comb begin
        edgeInc = edge_q;
        satInc  = sat_q;
        if (edgeSeen && edge_q != CNT_MAX)
            edgeInc = edge_q + CNT_W'(1);
        if (edgeInc == CNT_MAX)
            satInc = 1'b1;

        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        if (!enable) begin
            gate_d = '0;
            edge_d = '0;
            sat_d  = 1'b0;
        end else if (gate_q == GATE_LAST) begin
            gate_d  = '0;
            edge_d  = '0;
            sat_d   = 1'b0;
            freq_d  = edgeInc;
            ovf_d   = satInc;
            valid_d = 1'b1;
        end else begin
            gate_d = gate_q + GW'(1);
            edge_d = edgeInc;
            sat_d  = satInc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign freq     = freq_q;
    assign overflow = ovf_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: an 8-bit and a 4-bit instance share the
// same stimulus with a 100-cycle gate window.
module tb_frequency_meter;

    localparam int GATE = 100;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       sig_in;
    logic [7:0] freq8;
    logic       ovf8;
    logic       valid8;
    logic [3:0] freq4;
    logic       ovf4;
    logic       valid4;

    int sigPeriod;
    int sigPhase;
    logic sigLevel;
    int checks;
    int errors;
    int n;

    frequency_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sig_in   (sig_in),
        .freq     (freq8),
        .overflow (ovf8),
        .valid    (valid8)
    );

    frequency_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sig_in   (sig_in),
        .freq     (freq4),
        .overflow (ovf4),
        .valid    (valid4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave generator; a period of 0 drives the static sigLevel instead.
    initial begin
        sig_in   = 1'b0;
        sigPhase = 0;
        forever begin
            @(negedge clk);
            if (sigPeriod > 0) begin
                sigPhase++;
                if (sigPhase >= sigPeriod / 2) begin
                    sigPhase = 0;
                    sig_in   = ~sig_in;
                end
            end else begin
                sigPhase = 0;
                sig_in   = sigLevel;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Returns the number of rising clock edges until valid8 is seen high.
    task automatic waitValid(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!valid8 && cycles < limit);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        sigLevel  = 1'b0;
        sigPeriod = 2;

        repeat (5) begin
            @(negedge clk);
            checkOutput("reset_freq", 32'(freq8), 0);
            checkOutput("reset_overflow", 32'(ovf8), 0);
            checkOutput("reset_valid", 32'(valid8), 0);
        end
        sigPeriod = 0;
        sigLevel  = 1'b0;
        enable    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Valid lands in the 101st cycle: 100 counting edges, then the output register.
        waitValid(300, n);
        checkOutput("first_valid_edges", 32'(n), GATE);
        checkOutput("first_valid", 32'(valid8), 1);
        checkOutput("first_freq", 32'(freq8), 0);
        checkOutput("first_valid4", 32'(valid4), 1);
        @(negedge clk);
        checkOutput("valid_one_cycle", 32'(valid8), 0);

        sigPeriod = 10;
        waitValid(300, n);
        for (int w = 0; w < 3; w++) begin
            waitValid(300, n);
            checkOutput("sq10_period", 32'(n), GATE);
            checkOutput("sq10_freq", 32'(freq8), 10);
            checkOutput("sq10_overflow", 32'(ovf8), 0);
        end

        rst       = 1'b1;
        sigPeriod = 0;
        sigLevel  = 1'b1;
        enable    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        waitValid(300, n);
        checkOutput("high_w1_edges", 32'(n), GATE);
        checkOutput("high_w1_freq", 32'(freq8), 0);
        waitValid(300, n);
        checkOutput("high_w2_freq", 32'(freq8), 0);
        repeat (40) @(negedge clk);
        sigLevel = 1'b0;
        repeat (10) @(negedge clk);
        sigLevel = 1'b1;
        waitValid(300, n);
        checkOutput("high_w3_freq", 32'(freq8), 1);
        waitValid(300, n);
        checkOutput("high_w4_freq", 32'(freq8), 0);

        sigPeriod = 2;
        waitValid(300, n);
        waitValid(300, n);
        checkOutput("sat_freq4", 32'(freq4), 15);
        checkOutput("sat_overflow4", 32'(ovf4), 1);
        checkOutput("sat_valid4", 32'(valid4), 1);
        checkOutput("p2_freq8", 32'(freq8), 50);
        checkOutput("p2_overflow8", 32'(ovf8), 0);
        sigPeriod = 20;
        waitValid(300, n);
        waitValid(300, n);
        checkOutput("p20_freq4", 32'(freq4), 5);
        checkOutput("p20_overflow4", 32'(ovf4), 0);
        checkOutput("p20_freq8", 32'(freq8), 5);

        sigPeriod = 10;
        waitValid(300, n);
        waitValid(300, n);
        checkOutput("pre_drop_freq", 32'(freq8), 10);
        repeat (50) @(negedge clk);
        enable = 1'b0;
        repeat (30) begin
            @(negedge clk);
            checkOutput("disabled_valid", 32'(valid8), 0);
            checkOutput("disabled_freq_hold", 32'(freq8), 10);
        end
        enable = 1'b1;
        waitValid(300, n);
        checkOutput("reenable_edges", 32'(n), GATE);
        checkOutput("reenable_freq", 32'(freq8), 10);
        checkOutput("reenable_overflow", 32'(ovf8), 0);

        repeat (70) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_freq", 32'(freq8), 0);
        checkOutput("async_rst_overflow", 32'(ovf8), 0);
        checkOutput("async_rst_valid", 32'(valid8), 0);
        @(negedge clk);
        rst = 1'b0;
        waitValid(300, n);
        checkOutput("post_rst_edges", 32'(n), GATE);
        checkOutput("post_rst_valid", 32'(valid8), 1);
        waitValid(300, n);
        checkOutput("post_rst_period", 32'(n), GATE);
        checkOutput("post_rst_freq", 32'(freq8), 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frequency_meter.md
Name: frequency_meter

Overview:
- Measures the frequency of an external digital signal. Counts its rising edges over a fixed gate window derived from the system clock.
- Performs the inverse of the team's frequency divider: the divider turns the 12 MHz board clock into a slow tick, and this block turns an unknown signal back into a number of edges per gate period.
- Sits between a board input pin (or a divider output, in loopback) and the display/LED logic.
- Result is a registered count plus a one-cycle valid strobe per window.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz (informational; sets the GATE_CYCLES default).
- GATE_CYCLES, 12000000, gate window length in clk cycles (default gives 1 s, so the result is in Hz). Must be at least 4.
- CNT_W, 32, width of the edge counter and of the result.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  measurement enable. Low holds the block idle.
- sig_in  input  1  asynchronous signal under measurement.
- freq  output  CNT_W  rising-edge count of the last completed window.
- overflow  output  1  last window's count saturated.
- valid  output  1  one-cycle strobe: freq/overflow updated this cycle.

Behaviour:
- Reset (async, active-high) clears everything immediately: freq=0, overflow=0, valid=0, synchronizer flops=0, gate counter=0, edge counter=0, saturation flag=0.
- Input path:
  - sig_in passes through a 2-FF synchronizer, then a third register for edge detection.
  - edge = sync_q & ~prev_q.
  - Latency from an sig_in rising edge to the counter increment is 3 clk cycles.
- Edge counter:
  - Increments by 1 on each detected edge while enable=1.
  - Saturates at 2^CNT_W-1; reaching saturation sets the sticky sat flag for the current window.
  - Never wraps.
- Gate counter:
  - Counts 0..GATE_CYCLES-1 while enable=1; the terminal cycle is gate_cnt==GATE_CYCLES-1.
  - On the terminal cycle:
    - gate_cnt wraps to 0.
    - freq <= edge_cnt plus 1 if an edge is detected in that same cycle (saturating).
    - overflow <= sat (or saturation caused by that edge).
    - valid <= 1 on the next edge, so freq/overflow/valid change together.
    - edge_cnt and sat are cleared, or edge_cnt is set to 0 even if another edge occurs at that boundary. An edge on the terminal cycle belongs to the closing window.
- valid is high exactly one cycle per window, with period GATE_CYCLES cycles.
- The first valid after reset release (with enable=1) or after enable rises occurs GATE_CYCLES+1 cycles later: GATE_CYCLES cycles of counting plus 1 cycle of output register.
- enable=0:
  - gate_cnt and edge_cnt are forced to 0 synchronously; no valid is produced.
  - freq/overflow hold their last values.
  - The synchronizer keeps running.
  - Dropping enable mid-window discards the partial window.
- Edges within the last 3 cycles of a window (pipeline latency) are counted in the next window; this is accepted and documented.
- sig_in frequency above clk/2 is undefined (aliasing); no detection required.

Decomposition:
- Shared package freq_pkg:
  - CLK_HZ_DEFAULT = 12000000.
  - CNT_W_DEFAULT = 32.
  - GATE_1S = CLK_HZ_DEFAULT, shared with the frequency divider's max-count constant.
- Sub-module sync_edge_detect:
  - Ports clk, rst, async_in, sync_out, rise_pulse.
  - Holds the 2-FF synchronizer plus the edge register; reusable for button inputs.
- The gate counter, edge counter and output register stay in frequency_meter.

Test Plan (bench uses GATE_CYCLES=100, CNT_W=8 unless noted):
- Reset: hold rst=1 for 5 cycles with sig_in toggling -> freq=0, overflow=0, valid=0 throughout. Release with enable=1, sig_in=0 -> first valid exactly 101 cycles later with freq=0.
- Square wave, period 10 clk (5 high/5 low), enable=1 -> valid every 100 cycles. Every window after the first reports freq=10, overflow=0.
- sig_in held at 1 from before reset release -> no rising edge. Every window reports freq=0. A single 0->1 transition mid-window 3 -> window 3 reports 1, window 4 reports 0.
- Saturation with CNT_W=4, sig_in period 2 (50 edges/window) -> freq=15, overflow=1. Switching to period 20 (5 edges) -> next full window freq=5, overflow=0.
- enable dropped at gate cycle 50 and held low 30 cycles -> no valid in that span; freq holds its previous value. enable re-raised -> next valid exactly 101 cycles later with that window's full count (10 for period-10 input).
- rst pulsed high for 1 cycle at gate cycle 70 -> freq/overflow/valid go to 0 asynchronously (checked before the next clk edge). Next valid 101 cycles after release.
